// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared constants, FSM state encoding and salu opcode map
//                for the accumulator controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Datapath and opcode widths; these must match the salu instance.
    localparam int WIDTH   = 8;
    localparam int OPW     = 4;

    // Opcodes 0x0 .. NUM_OPS-1 are legal; anything above is rejected.
    localparam int NUM_OPS = 12;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // salu mux map.
    localparam logic [OPW-1:0] OP_AND  = 4'h0;  // a & b
    localparam logic [OPW-1:0] OP_OR   = 4'h1;  // a | b
    localparam logic [OPW-1:0] OP_XOR  = 4'h2;  // a ^ b
    localparam logic [OPW-1:0] OP_ADD  = 4'h3;  // a + b
    localparam logic [OPW-1:0] OP_SUB  = 4'h4;  // a - b
    localparam logic [OPW-1:0] OP_RSUB = 4'h5;  // b - a
    localparam logic [OPW-1:0] OP_NOTA = 4'h6;  // ~a
    localparam logic [OPW-1:0] OP_SHL  = 4'h7;  // a << 1
    localparam logic [OPW-1:0] OP_SHR  = 4'h8;  // a >> 1
    localparam logic [OPW-1:0] OP_INC  = 4'h9;  // a + 1
    localparam logic [OPW-1:0] OP_DEC  = 4'hA;  // a - 1
    localparam logic [OPW-1:0] OP_PASSB = 4'hB; // b

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_acc_ctrl
//  Description : Accumulator controller wrapped around an external
//                combinational salu. Accepts one request per valid/ready
//                handshake, feeds salu from registers, writes the result
//                back into the accumulator and presents it on an output
//                valid/ready handshake.
//  Options     : ALU_ACC_OPCNT_EN - adds a saturating 16-bit op_count port
//                counting completed output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = alu_pkg::WIDTH,
    parameter int OPW     = alu_pkg::OPW,
    parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_mux,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
`ifdef ALU_ACC_OPCNT_EN
    output logic             out_err,
    output logic [15:0]      op_count
`else
    output logic             out_err
`endif
);

    // One extra bit so NUM_OPS == 2**OPW still compares correctly.
    localparam logic [OPW:0] C_NUM_OPS = NUM_OPS[OPW:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [OPW-1:0]   op_q,    op_d;
    logic [WIDTH-1:0] opnd_q,  opnd_d;
    logic             err_q,   err_d;
    logic             op_illegal;

    assign op_illegal = ({1'b0, in_op} >= C_NUM_OPS);

    // Next-state and datapath update for the IDLE -> EXEC -> DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d   = in_op;
                    opnd_d = in_data;
                    if (in_load) begin
                        // Direct load bypasses salu; opcode is don't-care.
                        acc_d   = in_data;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (op_illegal) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                // salu has had a full cycle to settle on registered inputs.
                acc_d   = alu_result;
                err_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and datapath registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            opnd_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            err_q   <= err_d;
        end
    end

    // salu operands come straight from flops so they never glitch.
    assign alu_a     = acc_q;
    assign alu_b     = opnd_q;
    assign alu_mux   = op_q;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign out_zero  = (acc_q == '0);
    assign out_err   = err_q;

`ifdef ALU_ACC_OPCNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count output handshakes, holding at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Handshake counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_count = cnt_q;
`endif

endmodule : alu_acc_ctrl
`default_nettype wire

// File: tb/tb_alu_acc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_acc_ctrl
//  Description : Self-checking bench for alu_acc_ctrl with a behavioural
//                salu stub and an expected-result scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_acc_ctrl;

    localparam int W = 8;
    localparam int O = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_load;
    logic [O-1:0] in_op;
    logic [W-1:0] in_data;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [O-1:0] alu_mux;
    logic [W-1:0] alu_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic         out_err;
`ifdef ALU_ACC_OPCNT_EN
    logic [15:0]  op_count;
    int           hs_count;
`endif

    int n_checks   = 0;
    int n_failures = 0;

    // Scoreboard entries: {data, zero, err}.
    logic [W+1:0] sb_q[$];
    logic [W-1:0] model_acc;

    always #5 clk = ~clk;

    alu_acc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_op      (in_op),
        .in_data    (in_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mux    (alu_mux),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
`ifdef ALU_ACC_OPCNT_EN
        .out_err    (out_err),
        .op_count   (op_count)
`else
        .out_err    (out_err)
`endif
    );

    // Behavioural salu.
    function automatic logic [W-1:0] salu_model(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic [O-1:0] m);
        case (m)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a ^ b;
            4'h3: return a + b;
            4'h4: return a - b;
            4'h5: return b - a;
            4'h6: return ~a;
            4'h7: return a << 1;
            4'h8: return a >> 1;
            4'h9: return a + 8'd1;
            4'hA: return a - 8'd1;
            4'hB: return b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = salu_model(alu_a, alu_b, alu_mux);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, wait for acceptance, push the expected result.
    task automatic send(input logic ld, input logic [O-1:0] op, input logic [W-1:0] d);
        int          n;
        logic [W-1:0] exp_d;
        logic        exp_e;
        logic        is_alu;
        in_valid = 1'b1;
        in_load  = ld;
        in_op    = op;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        is_alu = 1'b0;
        if (ld) begin
            exp_d = d;
            exp_e = 1'b0;
        end else if (op >= 4'(12)) begin
            exp_d = model_acc;
            exp_e = 1'b1;
        end else begin
            exp_d  = salu_model(model_acc, d, op);
            exp_e  = 1'b0;
            is_alu = 1'b1;
        end
        sb_q.push_back({exp_d, (exp_d == 8'h00), exp_e});
        tick();
        in_valid = 1'b0;
        if (is_alu) begin
            check("exec_out_valid", 32'(out_valid), 32'd0);
            check("exec_in_ready",  32'(in_ready),  32'd0);
            check("exec_alu_a",     32'(alu_a),     32'(model_acc));
            check("exec_alu_b",     32'(alu_b),     32'(d));
            check("exec_alu_mux",   32'(alu_mux),   32'(op));
            tick();
        end
        model_acc = exp_d;
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    // Compare the presented result against the scoreboard and handshake.
    task automatic pop_compare();
        logic [W+1:0] e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[W+1:2]));
        check("out_zero", 32'(out_zero), 32'(e[1]));
        check("out_err",  32'(out_err),  32'(e[0]));
    endtask

    task automatic recv(input int stall);
        logic [W-1:0] held;
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'(held));
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        pop_compare();
        out_ready = 1'b1;
        tick();
`ifdef ALU_ACC_OPCNT_EN
        hs_count++;
`endif
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_load   = 1'b0;
        in_op     = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_acc = '0;
`ifdef ALU_ACC_OPCNT_EN
        hs_count  = 0;
`endif
        // Reset state with in_valid held high.
        repeat (3) tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_out_zero",  32'(out_zero),  32'd1);
        check("rst_out_err",   32'(out_err),   32'd0);
        check("rst_alu_a",     32'(alu_a),     32'h00);
`ifdef ALU_ACC_OPCNT_EN
        check("rst_op_count",  32'(op_count),  32'd0);
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Load, then ADD: 0x6A + 0x3B = 0xA5.
        send(1'b1, 4'h0, 8'h6A);
        recv(0);
        send(1'b0, 4'h3, 8'h3B);
        recv(0);

        // Illegal opcode keeps accumulator, then a legal op clears err.
        send(1'b0, 4'hC, 8'hFF);
        recv(0);
        send(1'b0, 4'h0, 8'h0F);
        recv(0);

        // Load with an out-of-range opcode is not an error.
        send(1'b1, 4'hF, 8'h3C);
        recv(0);

        // XOR with itself gives zero.
        send(1'b0, 4'h2, 8'h3C);
        recv(0);

        // Backpressure with the next request already waiting.
        send(1'b0, 4'h9, 8'h00);
        in_valid = 1'b1;
        in_load  = 1'b0;
        in_op    = 4'hA;
        in_data  = 8'h55;
        recv(5);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_acc",      32'(alu_a),    32'h01);
        send(1'b0, 4'hA, 8'h55);
        recv(2);

        // Reset during EXEC aborts the operation.
        send(1'b1, 4'h0, 8'h80);
        recv(0);
        in_valid = 1'b1;
        in_load  = 1'b0;
        in_op    = 4'h3;
        in_data  = 8'h11;
        tick();
        in_valid = 1'b0;
        check("midrst_in_exec", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_acc",       32'(out_data),  32'h00);
        tick();
        check("midrst_hold_valid", 32'(out_valid), 32'd0);
        rst_n     = 1'b1;
        model_acc = '0;
`ifdef ALU_ACC_OPCNT_EN
        check("midrst_op_count", 32'(op_count), 32'd0);
        hs_count = 0;
`endif
        tick();
        check("midrst_no_valid", 32'(out_valid), 32'd0);

        // Three completed handshakes after reset.
        send(1'b0, 4'h9, 8'h00);
        recv(0);
        send(1'b0, 4'hC, 8'h00);
        recv(1);
        send(1'b0, 4'h4, 8'h03);
        recv(0);
`ifdef ALU_ACC_OPCNT_EN
        check("op_count_3", 32'(op_count), 32'(hs_count));
`endif
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule : tb_alu_acc_ctrl
`default_nettype wire

// File: doc/alu_acc_ctrl.md
Name: alu_acc_ctrl

Overview:
Sequential accumulator controller that sits in front of, and behind, the 8-bit combinational salu. It accepts one operation per valid/ready handshake and drives salu with the accumulator (operanda), the latched operand (operandb) and the opcode (mux). It captures salu's result into the accumulator one cycle later, then presents the new accumulator value and flags on an output valid/ready handshake.

Parameters:
WIDTH, 8, datapath width; must match the salu operand/result width
OPW, 4, opcode width; must match the salu mux width
NUM_OPS, 12, number of legal opcodes (0x0..NUM_OPS-1); higher codes are illegal

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  controller can accept a request
in_load  in  1  1 = load accumulator directly from in_data (salu not used)
in_op  in  OPW  salu opcode
in_data  in  WIDTH  operand B, or load value when in_load=1
alu_a  out  WIDTH  to salu operanda (= accumulator)
alu_b  out  WIDTH  to salu operandb (= latched operand)
alu_mux  out  OPW  to salu mux (= latched opcode)
alu_result  in  WIDTH  from salu result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  WIDTH  accumulator value after the operation
out_zero  out  1  out_data == 0
out_err  out  1  illegal opcode; accumulator left unchanged

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0; op_reg=0; opnd_reg=0; in_ready=1; out_valid=0; out_err=0. out_zero=1 because out_data=acc=0. A reset mid-operation aborts the operation; no partial writeback.
- alu_a=acc, alu_b=opnd_reg, alu_mux=op_reg are driven from registers at all times, so they are glitch-free toward salu.
- States: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch in_op -> op_reg and in_data -> opnd_reg.
  - If in_load=1, acc <= in_data, err <= 0, go to DONE.
  - Else if in_op >= NUM_OPS, err <= 1, acc unchanged, go to DONE.
  - Else go to EXEC.
- EXEC: exactly one cycle, in_ready=0. salu settles combinationally on the registered inputs. At the end of the cycle: acc <= alu_result, err <= 0, go to DONE.
- DONE: out_valid=1, out_data=acc, out_zero=(acc==0), out_err=err, in_ready=0.
  - On out_ready, go to IDLE. out_valid drops in the next cycle.
  - out_data and flags stay stable while out_valid=1 and out_ready=0.
- Latency from accept to out_valid:
  - ALU op: 2 cycles.
  - Load or illegal opcode: 1 cycle.
- Throughput: one operation per 3 cycles (ALU) or 2 cycles (load/illegal) when out_ready is held at 1. There is no overlap: in_ready is low in EXEC and DONE.
- Width rules: the result is truncated to WIDTH by salu. The controller performs no arithmetic of its own.
- in_op is ignored when in_load=1, so illegal opcodes with in_load=1 are not errors.
- in_valid held high while in_ready=0 is legal. The request is taken when the controller returns to IDLE. in_* must stay stable until accepted.

Optional Feature:
ALU_ACC_OPCNT_EN.
- Defined: adds output op_count [15:0]. Reset value 0. Increments by 1 on each out_valid & out_ready handshake and saturates at 0xFFFF (no wrap-around). Loads and errors are counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH and OPW constants.
  - NUM_OPS.
  - state enum (IDLE=2'd0, EXEC=2'd1, DONE=2'd2).
  - opcode localparams 0x0..0xB matching the salu mux map.
- No sub-module. salu is instantiated beside this block at top level, not inside it. The bench may instantiate a behavioural salu stub or the real salu.

Test Plan:
1. Reset: hold rst_n=0, drive in_valid=1 -> in_ready=1, out_valid=0, out_data=0x00, out_zero=1, alu_a=0x00.
2. Load: in_load=1, in_data=0x6A, out_ready=1 -> out_valid=1 one cycle after accept; out_data=0x6A, out_zero=0, out_err=0.
3. ALU op: after step 2, in_op=0x3, in_data=0x3B; bench salu stub returns 0xA5 -> during EXEC alu_a=0x6A, alu_b=0x3B, alu_mux=0x3; out_data=0xA5 two cycles after accept.
4. Illegal op: in_op=0xC, in_data=0xFF -> out_err=1 after 1 cycle, out_data still 0xA5. A following op 0x0 clears out_err.
5. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0. A held in_valid is accepted only in the cycle after out_ready=1.
6. Mid-op reset, plus counter: assert rst_n=0 during EXEC -> acc=0, state IDLE, no out_valid. With ALU_ACC_OPCNT_EN, op_count=0 after reset and equals 3 after three completed handshakes.
